// File: rtl/mor1kx_rf_multiport.sv
// Multi-port GPR file with shadow contexts, generic forwarding sources,
// reset-time array clearing and a handshaked SPR GPR access port.
module mor1kx_rf_multiport #(
    parameter int OPTION_OPERAND_WIDTH     = 32,
    parameter int OPTION_RF_ADDR_WIDTH     = 5,
    parameter int OPTION_RF_NUM_SHADOW_GPR = 0,
    parameter int OPTION_RF_READ_PORTS     = 2,
    parameter int OPTION_RF_FWD_SOURCES    = 2,
    parameter int OPTION_RF_CLEAR_ON_RESET = 1,
    localparam int W   = OPTION_OPERAND_WIDTH,
    localparam int A   = OPTION_RF_ADDR_WIDTH,
    localparam int C   = (OPTION_RF_NUM_SHADOW_GPR == 0) ? 0 :
                         (OPTION_RF_NUM_SHADOW_GPR == 1) ? 1 : $clog2(OPTION_RF_NUM_SHADOW_GPR),
    localparam int CW  = (C > 0) ? C : 1,
    localparam int P   = OPTION_RF_READ_PORTS,
    localparam int S   = OPTION_RF_FWD_SOURCES,
    localparam int SW  = (S > 0) ? S : 1,
    localparam int PAW = A + C
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            rf_ready_o,
    input  logic [CW-1:0]   ctx_i,
    input  logic            rd_req_i,
    input  logic [P*A-1:0]  rd_adr_i,
    output logic [P*W-1:0]  rd_dat_o,
    input  logic [SW-1:0]   fwd_valid_i,
    input  logic [SW*A-1:0] fwd_adr_i,
    input  logic [SW*W-1:0] fwd_dat_i,
    input  logic            wb_we_i,
    input  logic [A-1:0]    wb_adr_i,
    input  logic [W-1:0]    wb_dat_i,
    input  logic            spr_stb_i,
    input  logic            spr_we_i,
    input  logic [PAW-1:0]  spr_adr_i,
    input  logic [W-1:0]    spr_dat_i,
    output logic            spr_ack_o,
    output logic [W-1:0]    spr_dat_o
);

    localparam int DEPTH = 1 << PAW;

    typedef enum logic {ST_INIT, ST_RUN} rf_state_e;
    typedef enum logic [1:0] {SPR_IDLE, SPR_WR_WAIT, SPR_RD, SPR_ACK} spr_state_e;

    // Context bits are dropped by the slice when no shadow sets exist.
    function automatic logic [PAW-1:0] phys(input logic [CW-1:0] ctx, input logic [A-1:0] adr);
        logic [CW+A-1:0] wide;
        wide = {ctx, adr};
        return wide[PAW-1:0];
    endfunction

    logic [W-1:0]   mem_q [DEPTH];

    rf_state_e      rf_state_q, rf_state_d;
    logic [PAW-1:0] clr_cnt_q, clr_cnt_d;
    logic           rf_ready_q, rf_ready_d;

    spr_state_e     spr_state_q, spr_state_d;
    logic           spr_ack_q, spr_ack_d;
    logic [W-1:0]   spr_dat_q, spr_dat_d;
    logic           spr_commit;

    logic [PAW-1:0] hold_adr_q [P];
    logic [PAW-1:0] hold_adr_d [P];
    logic [W-1:0]   ram_dat_q  [P];
    logic [W-1:0]   ram_dat_d  [P];
    logic           cap_vld_q  [P];
    logic           cap_vld_d  [P];
    logic [W-1:0]   cap_dat_q  [P];
    logic [W-1:0]   cap_dat_d  [P];
    logic           rd_seen_q, rd_seen_d;

    logic           mem_we;
    logic [PAW-1:0] mem_wa;
    logic [W-1:0]   mem_wd;

    logic           run;
    logic           wb_go;
    logic           rd_go;
    logic [PAW-1:0] wb_pa;

    assign run   = (rf_state_q == ST_RUN);
    assign wb_go = run & wb_we_i;
    assign rd_go = run & rd_req_i;
    assign wb_pa = phys(ctx_i, wb_adr_i);

    always_comb begin
        rf_state_d = rf_state_q;
        clr_cnt_d  = clr_cnt_q;
        rf_ready_d = rf_ready_q;
        if (rf_state_q == ST_INIT) begin
            clr_cnt_d = clr_cnt_q + PAW'(1);
            if (clr_cnt_q == '1) begin
                rf_state_d = ST_RUN;
                rf_ready_d = 1'b1;
            end
        end
    end

    // SPR writes only commit while writeback is idle, so they never collide with it.
    always_comb begin
        spr_state_d = spr_state_q;
        spr_ack_d   = 1'b0;
        spr_dat_d   = spr_dat_q;
        spr_commit  = 1'b0;
        case (spr_state_q)
            SPR_IDLE: begin
                if (run && spr_stb_i) begin
                    if (!spr_we_i) begin
                        spr_state_d = SPR_RD;
                    end else if (wb_we_i) begin
                        spr_state_d = SPR_WR_WAIT;
                    end else begin
                        spr_commit  = 1'b1;
                        spr_ack_d   = 1'b1;
                        spr_state_d = SPR_ACK;
                    end
                end
            end
            SPR_WR_WAIT: begin
                if (!spr_stb_i) begin
                    spr_state_d = SPR_IDLE;
                end else if (!wb_we_i) begin
                    spr_commit  = 1'b1;
                    spr_ack_d   = 1'b1;
                    spr_state_d = SPR_ACK;
                end
            end
            SPR_RD: begin
                if (!spr_stb_i) begin
                    spr_state_d = SPR_IDLE;
                end else begin
                    spr_dat_d   = mem_q[spr_adr_i];
                    spr_ack_d   = 1'b1;
                    spr_state_d = SPR_ACK;
                end
            end
            default: spr_state_d = SPR_IDLE;
        endcase
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = '0;
        if (!run) begin
            mem_we = 1'b1;
            mem_wa = clr_cnt_q;
        end else if (wb_we_i) begin
            mem_we = 1'b1;
            mem_wa = wb_pa;
            mem_wd = wb_dat_i;
        end else if (spr_commit) begin
            mem_we = 1'b1;
            mem_wa = spr_adr_i;
            mem_wd = spr_dat_i;
        end
    end

    always_comb begin
        rd_seen_d = rd_seen_q | rd_go;
        for (int unsigned p = 0; p < P; p++) begin
            logic [PAW-1:0] new_pa;
            new_pa       = phys(ctx_i, rd_adr_i[p*A +: A]);
            hold_adr_d[p] = hold_adr_q[p];
            ram_dat_d[p]  = ram_dat_q[p];
            cap_vld_d[p]  = cap_vld_q[p];
            cap_dat_d[p]  = cap_dat_q[p];
            if (rd_go) begin
                hold_adr_d[p] = new_pa;
                ram_dat_d[p]  = mem_q[new_pa];
                cap_vld_d[p]  = wb_go && (wb_pa == new_pa);
                cap_dat_d[p]  = wb_dat_i;
            end else if (wb_go && rd_seen_q && (wb_pa == hold_adr_q[p])) begin
                cap_vld_d[p] = 1'b1;
                cap_dat_d[p] = wb_dat_i;
            end
        end
    end

    always_comb begin
        rd_dat_o = '0;
        for (int unsigned p = 0; p < P; p++) begin
            logic         found;
            logic [W-1:0] val;
            found = 1'b0;
            val   = cap_vld_q[p] ? cap_dat_q[p] : ram_dat_q[p];
            for (int unsigned s = 0; s < S; s++) begin
                if (!found && fwd_valid_i[s] &&
                    (phys(ctx_i, fwd_adr_i[s*A +: A]) == hold_adr_q[p])) begin
                    found = 1'b1;
                    val   = fwd_dat_i[s*W +: W];
                end
            end
            rd_dat_o[p*W +: W] = val;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_state_q  <= (OPTION_RF_CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
            clr_cnt_q   <= '0;
            rf_ready_q  <= (OPTION_RF_CLEAR_ON_RESET == 0);
            spr_state_q <= SPR_IDLE;
            spr_ack_q   <= 1'b0;
            spr_dat_q   <= '0;
            rd_seen_q   <= 1'b0;
            for (int unsigned p = 0; p < P; p++) begin
                hold_adr_q[p] <= '0;
                ram_dat_q[p]  <= '0;
                cap_vld_q[p]  <= 1'b0;
                cap_dat_q[p]  <= '0;
            end
        end else begin
            rf_state_q  <= rf_state_d;
            clr_cnt_q   <= clr_cnt_d;
            rf_ready_q  <= rf_ready_d;
            spr_state_q <= spr_state_d;
            spr_ack_q   <= spr_ack_d;
            spr_dat_q   <= spr_dat_d;
            rd_seen_q   <= rd_seen_d;
            for (int unsigned p = 0; p < P; p++) begin
                hold_adr_q[p] <= hold_adr_d[p];
                ram_dat_q[p]  <= ram_dat_d[p];
                cap_vld_q[p]  <= cap_vld_d[p];
                cap_dat_q[p]  <= cap_dat_d[p];
            end
        end
    end

    assign rf_ready_o = rf_ready_q;
    assign spr_ack_o  = spr_ack_q;
    assign spr_dat_o  = spr_dat_q;

endmodule

// File: tb/tb_mor1kx_rf_multiport.sv
// Directed bench: W=32, A=5, one shadow set (C=1), 2 read ports, 2 forwarding sources.
module tb_mor1kx_rf_multiport;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rf_ready_o;
    logic [0:0]  ctx_i;
    logic        rd_req_i;
    logic [9:0]  rd_adr_i;
    logic [63:0] rd_dat_o;
    logic [1:0]  fwd_valid_i;
    logic [9:0]  fwd_adr_i;
    logic [63:0] fwd_dat_i;
    logic        wb_we_i;
    logic [4:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        spr_stb_i;
    logic        spr_we_i;
    logic [5:0]  spr_adr_i;
    logic [31:0] spr_dat_i;
    logic        spr_ack_o;
    logic [31:0] spr_dat_o;

    int tests = 0;
    int fails = 0;

    mor1kx_rf_multiport #(
        .OPTION_OPERAND_WIDTH    (32),
        .OPTION_RF_ADDR_WIDTH    (5),
        .OPTION_RF_NUM_SHADOW_GPR(1),
        .OPTION_RF_READ_PORTS    (2),
        .OPTION_RF_FWD_SOURCES   (2),
        .OPTION_RF_CLEAR_ON_RESET(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rf_ready_o (rf_ready_o),
        .ctx_i      (ctx_i),
        .rd_req_i   (rd_req_i),
        .rd_adr_i   (rd_adr_i),
        .rd_dat_o   (rd_dat_o),
        .fwd_valid_i(fwd_valid_i),
        .fwd_adr_i  (fwd_adr_i),
        .fwd_dat_i  (fwd_dat_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .spr_stb_i  (spr_stb_i),
        .spr_we_i   (spr_we_i),
        .spr_adr_i  (spr_adr_i),
        .spr_dat_i  (spr_dat_i),
        .spr_ack_o  (spr_ack_o),
        .spr_dat_o  (spr_dat_o)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ready(output int n, output int acks);
        n = 0;
        acks = 0;
        do begin
            step();
            n++;
            if (spr_ack_o) acks++;
        end while (!rf_ready_o && n < 200);
    endtask

    task automatic test_reset();
        int n, acks;
        rst_n = 1'b0;
        repeat (3) step();
        tests++; if (rf_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", rf_ready_o); end
        tests++; if (rd_dat_o !== 64'h0) begin fails++; $display("FAIL reset_rd_dat got %h want 0", rd_dat_o); end
        tests++; if (spr_ack_o !== 1'b0) begin fails++; $display("FAIL reset_spr_ack got %b want 0", spr_ack_o); end
        tests++; if (spr_dat_o !== 32'h0) begin fails++; $display("FAIL reset_spr_dat got %h want 0", spr_dat_o); end
        rst_n = 1'b1;
        wait_ready(n, acks);
        tests++; if (n !== 64) begin fails++; $display("FAIL init_length got %0d cycles want 64", n); end
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 32; a += 2) begin
                ctx_i    = 1'(c);
                rd_req_i = 1'b1;
                rd_adr_i = {5'(a + 1), 5'(a)};
                step();
                tests++;
                if (rd_dat_o !== 64'h0) begin
                    fails++; $display("FAIL clear_read ctx%0d r%0d got %h want 0", c, a, rd_dat_o);
                end
            end
        end
        rd_req_i = 1'b0;
        ctx_i    = 1'b0;
    endtask

    task automatic test_wb_capture();
        wb_we_i = 1'b1; wb_adr_i = 5'd3; wb_dat_i = 32'hDEADBEEF;
        rd_req_i = 1'b1; rd_adr_i = {5'd4, 5'd3};
        step();
        rd_req_i = 1'b0; wb_we_i = 1'b0;
        tests++; if (rd_dat_o[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL same_cycle_capture got %h want deadbeef", rd_dat_o[31:0]); end
        tests++; if (rd_dat_o[63:32] !== 32'h0) begin fails++; $display("FAIL capture_other_port got %h want 0", rd_dat_o[63:32]); end
        step(); step();
        tests++; if (rd_dat_o[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL capture_hold got %h want deadbeef", rd_dat_o[31:0]); end
        wb_we_i = 1'b1; wb_adr_i = 5'd4; wb_dat_i = 32'h55;
        step();
        wb_we_i = 1'b0;
        tests++; if (rd_dat_o[63:32] !== 32'h55) begin fails++; $display("FAIL hold_capture got %h want 55", rd_dat_o[63:32]); end
        tests++; if (rd_dat_o[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL hold_unrelated got %h want deadbeef", rd_dat_o[31:0]); end
        rd_req_i = 1'b1; rd_adr_i = {5'd4, 5'd3};
        step();
        rd_req_i = 1'b0;
        tests++; if (rd_dat_o !== {32'h55, 32'hDEADBEEF}) begin fails++; $display("FAIL ram_reread got %h want 00000055deadbeef", rd_dat_o); end
    endtask

    task automatic test_fwd();
        wb_we_i = 1'b1; wb_adr_i = 5'd5; wb_dat_i = 32'h55AA;
        step();
        wb_we_i = 1'b0;
        rd_req_i = 1'b1; rd_adr_i = {5'd4, 5'd5};
        step();
        rd_req_i = 1'b0;
        tests++; if (rd_dat_o[31:0] !== 32'h55AA) begin fails++; $display("FAIL fwd_base got %h want 55aa", rd_dat_o[31:0]); end
        fwd_valid_i = 2'b11; fwd_adr_i = {5'd5, 5'd5}; fwd_dat_i = {32'h22, 32'h11};
        #1;
        tests++; if (rd_dat_o[31:0] !== 32'h11) begin fails++; $display("FAIL fwd_youngest got %h want 11", rd_dat_o[31:0]); end
        tests++; if (rd_dat_o[63:32] !== 32'h55) begin fails++; $display("FAIL fwd_other_port got %h want 55", rd_dat_o[63:32]); end
        fwd_valid_i = 2'b10;
        #1;
        tests++; if (rd_dat_o[31:0] !== 32'h22) begin fails++; $display("FAIL fwd_src1 got %h want 22", rd_dat_o[31:0]); end
        fwd_valid_i = 2'b11; fwd_adr_i = {5'd5, 5'd6};
        #1;
        tests++; if (rd_dat_o[31:0] !== 32'h22) begin fails++; $display("FAIL fwd_addr_miss got %h want 22", rd_dat_o[31:0]); end
        fwd_valid_i = 2'b00;
        #1;
        tests++; if (rd_dat_o[31:0] !== 32'h55AA) begin fails++; $display("FAIL fwd_none got %h want 55aa", rd_dat_o[31:0]); end
        step();
    endtask

    task automatic test_spr();
        spr_stb_i = 1'b1; spr_we_i = 1'b1; spr_adr_i = 6'd7; spr_dat_i = 32'h1234;
        wb_we_i = 1'b1; wb_adr_i = 5'd10; wb_dat_i = 32'hA0;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++; if (spr_ack_o !== 1'b0) begin fails++; $display("FAIL spr_wait_ack cycle %0d got %b want 0", k, spr_ack_o); end
        end
        wb_we_i = 1'b0;
        step();
        tests++; if (spr_ack_o !== 1'b1) begin fails++; $display("FAIL spr_wr_ack got %b want 1", spr_ack_o); end
        spr_stb_i = 1'b0;
        step();
        tests++; if (spr_ack_o !== 1'b0) begin fails++; $display("FAIL spr_ack_single got %b want 0", spr_ack_o); end
        spr_stb_i = 1'b1; spr_we_i = 1'b0; spr_adr_i = 6'd7;
        step();
        tests++; if (spr_ack_o !== 1'b0) begin fails++; $display("FAIL spr_rd_early got %b want 0", spr_ack_o); end
        step();
        tests++; if (spr_ack_o !== 1'b1) begin fails++; $display("FAIL spr_rd_ack got %b want 1", spr_ack_o); end
        tests++; if (spr_dat_o !== 32'h1234) begin fails++; $display("FAIL spr_rd_dat got %h want 1234", spr_dat_o); end
        spr_stb_i = 1'b0;
        step();
        spr_stb_i = 1'b1; spr_we_i = 1'b1; spr_adr_i = 6'd40; spr_dat_i = 32'hCAFE;
        step();
        tests++; if (spr_ack_o !== 1'b1) begin fails++; $display("FAIL spr_wr_idle_ack got %b want 1", spr_ack_o); end
        spr_stb_i = 1'b0;
        ctx_i = 1'b1; rd_req_i = 1'b1; rd_adr_i = {5'd0, 5'd8};
        step();
        rd_req_i = 1'b0;
        tests++; if (rd_dat_o[31:0] !== 32'hCAFE) begin fails++; $display("FAIL spr_wr_visible got %h want cafe", rd_dat_o[31:0]); end
        ctx_i = 1'b0; rd_req_i = 1'b1; rd_adr_i = {5'd0, 5'd10};
        step();
        rd_req_i = 1'b0;
        tests++; if (rd_dat_o[31:0] !== 32'hA0) begin fails++; $display("FAIL wb_during_spr got %h want a0", rd_dat_o[31:0]); end
    endtask

    task automatic test_ctx();
        ctx_i = 1'b0; wb_we_i = 1'b1; wb_adr_i = 5'd2; wb_dat_i = 32'hA;
        step();
        ctx_i = 1'b1; wb_dat_i = 32'hB;
        step();
        wb_we_i = 1'b0;
        ctx_i = 1'b0; rd_req_i = 1'b1; rd_adr_i = {5'd0, 5'd2};
        step();
        tests++; if (rd_dat_o[31:0] !== 32'hA) begin fails++; $display("FAIL ctx0_read got %h want a", rd_dat_o[31:0]); end
        ctx_i = 1'b1;
        step();
        rd_req_i = 1'b0;
        tests++; if (rd_dat_o[31:0] !== 32'hB) begin fails++; $display("FAIL ctx1_read got %h want b", rd_dat_o[31:0]); end
        ctx_i = 1'b0;
        step();
        tests++; if (rd_dat_o[31:0] !== 32'hB) begin fails++; $display("FAIL ctx_change_hold got %h want b", rd_dat_o[31:0]); end
        spr_stb_i = 1'b1; spr_we_i = 1'b0; spr_adr_i = 6'd34;
        step(); step();
        tests++; if (spr_ack_o !== 1'b1 || spr_dat_o !== 32'hB) begin fails++; $display("FAIL spr_rd_34 got ack %b dat %h want ack 1 dat b", spr_ack_o, spr_dat_o); end
        spr_stb_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int n, acks;
        spr_stb_i = 1'b1; spr_we_i = 1'b0; spr_adr_i = 6'd34;
        step();
        rst_n = 1'b0;
        #1;
        tests++; if (spr_ack_o !== 1'b0) begin fails++; $display("FAIL mid_spr_ack got %b want 0", spr_ack_o); end
        step();
        tests++; if (spr_ack_o !== 1'b0 || spr_dat_o !== 32'h0) begin fails++; $display("FAIL mid_spr_state got ack %b dat %h want 0", spr_ack_o, spr_dat_o); end
        tests++; if (rd_dat_o !== 64'h0) begin fails++; $display("FAIL mid_rst_rd_dat got %h want 0", rd_dat_o); end
        spr_stb_i = 1'b0;
        rst_n = 1'b1;
        repeat (10) step();
        tests++; if (rf_ready_o !== 1'b0) begin fails++; $display("FAIL mid_init_ready got %b want 0", rf_ready_o); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_ready(n, acks);
        tests++; if (n !== 64) begin fails++; $display("FAIL init_restart got %0d cycles want 64", n); end
        tests++; if (acks !== 0) begin fails++; $display("FAIL init_spr_ack got %0d acks want 0", acks); end
        ctx_i = 1'b1; rd_req_i = 1'b1; rd_adr_i = {5'd5, 5'd2};
        step();
        rd_req_i = 1'b0;
        tests++; if (rd_dat_o !== 64'h0) begin fails++; $display("FAIL recleared got %h want 0", rd_dat_o); end
    endtask

    initial begin
        rst_n = 1'b0; ctx_i = 1'b0; rd_req_i = 1'b0; rd_adr_i = '0;
        fwd_valid_i = '0; fwd_adr_i = '0; fwd_dat_i = '0;
        wb_we_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0;
        spr_stb_i = 1'b0; spr_we_i = 1'b0; spr_adr_i = '0; spr_dat_i = '0;
        test_reset();
        test_wb_capture();
        test_fwd();
        test_spr();
        test_ctx();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mor1kx_rf_multiport.md
# mor1kx_rf_multiport

Parametrised successor to the cappuccino register file. It has N read ports, S generic forwarding sources in place of fixed execute/ctrl/wb bypass paths, and shadow GPR contexts selected at run time. A reset-driven clearing state machine zeroes the array, and a handshaked SPR GPR access port arbitrates with writeback. It sits between fetch/decode and the writeback stage of the cappuccino pipeline.

## Interface
- OPTION_OPERAND_WIDTH, 32, data width W
- OPTION_RF_ADDR_WIDTH, 5, architectural GPR address width A
- OPTION_RF_NUM_SHADOW_GPR, 0, number of shadow sets; context width C = 0 if 0, 1 if 1, else clog2(n)
- OPTION_RF_READ_PORTS, 2, number of read ports P (1..4)
- OPTION_RF_FWD_SOURCES, 2, number of forwarding sources S (0..4); index 0 is the youngest
- OPTION_RF_CLEAR_ON_RESET, 1, 1 = zero the array after reset via the INIT state
- clk  in  1  clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- rf_ready_o  out  1  array usable
- ctx_i  in  max(C,1)  active shadow context; ignored when C = 0
- rd_req_i  in  1  latch new read addresses
- rd_adr_i  in  P*A  read addresses; port p uses bits [p*A +: A]
- rd_dat_o  out  P*W  read data, one word per port
- fwd_valid_i  in  S  forwarding source valid
- fwd_adr_i  in  S*A  forwarding destination addresses
- fwd_dat_i  in  S*W  forwarding data
- wb_we_i  in  1  writeback enable
- wb_adr_i  in  A  writeback address
- wb_dat_i  in  W  writeback data
- spr_stb_i  in  1  SPR GPR access strobe
- spr_we_i  in  1  SPR write when 1, read when 0
- spr_adr_i  in  A+C  flat SPR GPR index
- spr_dat_i  in  W  SPR write data
- spr_ack_o  out  1  SPR access done
- spr_dat_o  out  W  SPR read data

## Operation
- Physical address: {ctx, adr}, A+C bits. Reads use ctx_i sampled at rd_req_i; writes use ctx_i at write time.
- FSM INIT:
  - Entered on reset when OPTION_RF_CLEAR_ON_RESET = 1.
  - A counter walks 0..2^(A+C)-1, writing 0 at each address.
  - rf_ready_o = 0 throughout; wb_we_i, rd_req_i and spr_stb_i are ignored.
  - The state moves to RUN after the last address is written.
- FSM RUN: normal operation. With OPTION_RF_CLEAR_ON_RESET = 0, reset enters RUN directly.
- Read: on rd_req_i, every port registers its physical address and issues a RAM read. The RAM has no internal bypass.
- Per-port hold capture:
  - Captures a writeback that matches the held address while no new rd_req_i arrives.
  - A writeback in the same cycle as rd_req_i that matches the new address is also captured.
  - rd_req_i clears the old capture.
- rd_dat_o mux per port, highest priority first:
  1. Lowest-index valid fwd_* whose {ctx_i, fwd_adr} equals the held address.
  2. Captured writeback data.
  3. RAM output.
- Before the first rd_req_i after reset, rd_dat_o = 0 unless a forwarding source matches.
- Write port priority: INIT clear > wb_we_i > SPR write. A third RAM copy serves SPR reads.
- SPR FSM states: IDLE, WR_WAIT, RD, ACK.
  - Write: IDLE → WR_WAIT while wb_we_i is 1; the write commits on the first cycle with wb_we_i = 0, with ack in that same cycle.
  - Read: IDLE → RD (RAM access) → ACK. spr_dat_o is valid with ack.
  - ACK → IDLE. spr_ack_o is 1 for exactly one cycle per access.
  - If spr_stb_i drops before ack, the FSM returns to IDLE. A write not yet committed is dropped.

## Timing
- Reset values: rf_ready_o 0 (1 if CLEAR=0), rd_dat_o 0, spr_ack_o 0, spr_dat_o 0, FSMs in INIT/IDLE, captures invalid.
- INIT lasts 2^(A+C) cycles after rst_n rises; rf_ready_o rises the following cycle.
- Read latency: rd_dat_o reflects the new address 1 cycle after rd_req_i, then holds until the next rd_req_i. Forwarding is combinational on every cycle.
- Writeback-to-read: a write in cycle t is visible to a same-address rd_req_i in cycle t via capture, and from the RAM for requests at t+1 and later.
- SPR write latency: 1 cycle when wb_we_i is idle, otherwise 1 cycle after wb_we_i drops.
- SPR read latency: ack 2 cycles after strobe.
- ctx_i changes only when no forwarding source is valid. A change mid-hold does not alter held data.
- Reset mid-INIT restarts the walk from 0. Reset mid-SPR access drops the access without ack.

## Test plan
- Reset with CLEAR=1, A=5, C=1 → rf_ready_o low for 64 cycles, then high; all 64 reads return 0.
- wb write r3 = 0xDEADBEEF and rd_req port0 = r3 in the same cycle → rd_dat_o[0] = 0xDEADBEEF next cycle; a later re-read returns the same value from the RAM.
- Held r5 with fwd0 = r5/0x11 and fwd1 = r5/0x22 both valid → 0x11; with fwd0 dropped → 0x22; with both dropped → RAM value.
- SPR write r7 = 0x1234 while wb_we_i is high for 3 cycles → ack 1 cycle after wb_we_i falls; SPR read of r7 → ack at +2 cycles, spr_dat_o = 0x1234.
- Write r2 = 0xA in ctx 0 and r2 = 0xB in ctx 1 → reads return 0xA in ctx 0 and 0xB in ctx 1; the SPR read at index 34 returns 0xB.
- rst_n asserted mid-INIT and mid-SPR read → INIT restarts from 0, spr_ack_o stays 0, rd_dat_o = 0.
